// File: rtl/hazard_issue_stage.sv
// Fetch/issue stage: walks the instruction memory, checks each fetch against recently issued
// destinations and inserts noop bubbles until a RAW producer has left the hazard window.
module hazard_issue_stage #(
    parameter int IMEM_DEPTH = 8,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int HAZ_WINDOW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [7:0]        id_instr,
    output logic              bubble,
    output logic [7:0]        stall_cnt,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_DEPTH - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic              hist_valid_r [HAZ_WINDOW];
    logic [2:0]        hist_dest_r  [HAZ_WINDOW];
    logic              hazard_s;
    logic              id_valid_r;
    logic [7:0]        id_instr_r;
    logic              bubble_r;
    logic [7:0]        stall_cnt_r;
    logic              done_r;
    logic [ADDR_W-1:0] imem_addr_s;

    // lw reads rs; add and sw read rs and rd; r0 never creates a dependency
    function automatic logic reads_reg(input logic [7:0] instr, input logic [2:0] r);
        logic hit;
        hit = 1'b0;
        case (instr[7:6])
            2'b11:        hit = (instr[5:3] == r);
            2'b01, 2'b10: hit = (instr[5:3] == r) || (instr[2:0] == r);
            default:      hit = 1'b0;
        endcase
        return hit && (r != 3'b000);
    endfunction

    function automatic logic writes_reg(input logic [7:0] instr);
        return ((instr[7:6] == 2'b11) || (instr[7:6] == 2'b01)) && (instr[2:0] != 3'b000);
    endfunction

    // RAW check of the fetched instruction against every valid history slot
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            hazard_s = hazard_s | (hist_valid_r[i] & reads_reg(imem_data, hist_dest_r[i]));
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a low id_ready freezes everything, including start
    always_comb begin
        state_next_s = state_r;
        if (!id_ready) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_next_s = ST_RUN;
                    else       state_next_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (!hazard_s && (pc_r == LAST_PC)) state_next_s = ST_DONE;
                    else                                 state_next_s = ST_RUN;
                end
                ST_DONE: begin
                    if (start) state_next_s = ST_RUN;
                    else       state_next_s = ST_DONE;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: fetch address
    always_comb begin
        imem_addr_s = '0;
        case (state_r)
            ST_IDLE:          imem_addr_s = '0;
            ST_RUN, ST_DONE:  imem_addr_s = pc_r;
            default:          imem_addr_s = '0;
        endcase
    end

    // Issue datapath: PC, hazard history, registered ID outputs and stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r        <= '0;
            id_valid_r  <= 1'b0;
            id_instr_r  <= 8'h00;
            bubble_r    <= 1'b0;
            stall_cnt_r <= 8'h00;
            done_r      <= 1'b0;
            for (int i = 0; i < HAZ_WINDOW; i++) begin
                hist_valid_r[i] <= 1'b0;
                hist_dest_r[i]  <= 3'b000;
            end
        end else if (id_ready) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    id_valid_r <= 1'b0;
                    if (start) begin
                        pc_r        <= '0;
                        bubble_r    <= 1'b0;
                        stall_cnt_r <= 8'h00;
                        done_r      <= 1'b0;
                        for (int i = 0; i < HAZ_WINDOW; i++) begin
                            hist_valid_r[i] <= 1'b0;
                            hist_dest_r[i]  <= 3'b000;
                        end
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_RUN: begin
                    id_valid_r <= 1'b1;
                    for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
                        hist_valid_r[i] <= hist_valid_r[i-1];
                        hist_dest_r[i]  <= hist_dest_r[i-1];
                    end
                    if (hazard_s) begin
                        id_instr_r      <= 8'h00;
                        bubble_r        <= 1'b1;
                        hist_valid_r[0] <= 1'b0;
                        hist_dest_r[0]  <= 3'b000;
                        if (stall_cnt_r != 8'hFF) stall_cnt_r <= stall_cnt_r + 8'h01;
                        else                      stall_cnt_r <= stall_cnt_r;
                    end else begin
                        id_instr_r      <= imem_data;
                        bubble_r        <= 1'b0;
                        hist_valid_r[0] <= writes_reg(imem_data);
                        hist_dest_r[0]  <= imem_data[2:0];
                        if (pc_r == LAST_PC) begin
                            done_r <= 1'b1;
                        end else begin
                            pc_r <= pc_r + ADDR_W'(1'b1);
                        end
                    end
                end
                default: begin
                    id_valid_r <= 1'b0;
                end
            endcase
        end else begin
            pc_r <= pc_r;
        end
    end

    assign imem_addr = imem_addr_s;
    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign bubble    = bubble_r;
    assign stall_cnt = stall_cnt_r;
    assign done      = done_r;

endmodule

// File: tb/tb_hazard_issue_stage.sv
// Scoreboard bench for hazard_issue_stage: expected issue slots are queued per program and
// popped as the stage issues them.
module tb_hazard_issue_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] imem_addr;
    logic [7:0] imem_data;
    logic       id_ready;
    logic       id_valid;
    logic [7:0] id_instr;
    logic       bubble;
    logic [7:0] stall_cnt;
    logic       done;

    logic [7:0] imem [8];
    logic [8:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;

    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    hazard_issue_stage dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .bubble    (bubble),
        .stall_cnt (stall_cnt),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2,
                        input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] i5,
                        input logic [7:0] i6, input logic [7:0] i7);
        imem[0] = i0; imem[1] = i1; imem[2] = i2; imem[3] = i3;
        imem[4] = i4; imem[5] = i5; imem[6] = i6; imem[7] = i7;
    endtask

    task automatic push(input logic [7:0] ins, input logic bub);
        exp_q.push_back({ins, bub});
    endtask

    task automatic push_noops(input int n);
        for (int i = 0; i < n; i++) push(8'h00, 1'b0);
    endtask

    // Start a run and compare every issued slot; optionally freeze or reset after a given issue
    task automatic run_prog(input string name, input int exp_stall, input int hold_at,
                            input int hold_stall, input int reset_at);
        int         issues;
        int         cyc;
        logic [8:0] e;
        issues = 0;
        cyc    = 0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, " valid_after_start"}, 32'(id_valid), 32'd0);
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (id_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq({name, " extra_issue"}, {23'd0, id_instr, bubble}, 32'h1FF);
                    break;
                end
                e = exp_q.pop_front();
                check_eq({name, " slot"}, {23'd0, id_instr, bubble}, {23'd0, e});
                issues++;
                if (issues == hold_at) begin
                    id_ready = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(posedge clk); #1;
                        check_eq({name, " hold_slot"}, {22'd0, id_valid, id_instr, bubble},
                                 {22'd0, 1'b1, e});
                        check_eq({name, " hold_stall"}, 32'(stall_cnt), 32'(hold_stall));
                    end
                    id_ready = 1'b1;
                end
                if (issues == reset_at) begin
                    check_eq({name, " pre_reset_stall"}, 32'(stall_cnt), 32'(exp_stall));
                    check_eq({name, " pre_reset_pc"}, 32'(imem_addr), 32'd4);
                    #2 reset = 1'b1;
                    #1;
                    check_eq({name, " rst_valid"}, 32'(id_valid), 32'd0);
                    check_eq({name, " rst_done"}, 32'(done), 32'd0);
                    check_eq({name, " rst_stall"}, 32'(stall_cnt), 32'd0);
                    check_eq({name, " rst_pc"}, 32'(imem_addr), 32'd0);
                    exp_q.delete();
                    @(posedge clk);
                    @(negedge clk);
                    reset = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(posedge clk); #1;
                        check_eq({name, " idle_after_rst"}, {30'd0, id_valid, done}, 32'd0);
                    end
                    return;
                end
            end else if (done) begin
                break;
            end
        end
        check_eq({name, " drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({name, " done"}, 32'(done), 32'd1);
        check_eq({name, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check_eq({name, " valid_low"}, 32'(id_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({name, " pc_no_wrap"}, {28'd0, done, imem_addr}, {28'd0, 1'b1, 3'd7});
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        id_ready = 1'b1;
        load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        check_eq("reset_state", {20'd0, id_valid, done, bubble, stall_cnt, imem_addr},
                 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // all independent instructions
        load(8'hC1, 8'h5B, 8'h64, 8'hAD, 8'hF6, 8'h3F, 8'hC7, 8'h52);
        push(8'hC1, 1'b0); push(8'h5B, 1'b0); push(8'h64, 1'b0); push(8'hAD, 1'b0);
        push(8'hF6, 1'b0); push(8'h3F, 1'b0); push(8'hC7, 1'b0); push(8'h52, 1'b0);
        run_prog("indep", 0, 0, 0, 0);

        // distance-1 dependency: two bubbles
        load(8'hC1, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC1, 1'b0); push(8'h00, 1'b1); push(8'h00, 1'b1); push(8'h4A, 1'b0);
        push_noops(6);
        run_prog("dist1", 2, 0, 0, 0);

        // distance-2 dependency: one bubble
        load(8'hC1, 8'h5B, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC1, 1'b0); push(8'h5B, 1'b0); push(8'h00, 1'b1); push(8'h4A, 1'b0);
        push_noops(5);
        run_prog("dist2", 1, 0, 0, 0);

        // freeze during the first bubble
        load(8'hC1, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC1, 1'b0); push(8'h00, 1'b1); push(8'h00, 1'b1); push(8'h4A, 1'b0);
        push_noops(6);
        run_prog("freeze", 2, 2, 1, 0);

        // r0 never hazards
        load(8'hC8, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC8, 1'b0); push(8'h80, 1'b0);
        push_noops(6);
        run_prog("r0", 0, 0, 0, 0);

        // sw reads its rd field
        load(8'hC1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC1, 1'b0); push(8'h00, 1'b1); push(8'h00, 1'b1); push(8'h81, 1'b0);
        push_noops(6);
        run_prog("sw_src", 2, 0, 0, 0);

        // reset at PC 4, then a clean run from PC 0
        load(8'hC1, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push(8'hC1, 1'b0); push(8'h00, 1'b1); push(8'h00, 1'b1); push(8'h4A, 1'b0);
        push_noops(6);
        run_prog("abort", 2, 0, 0, 6);

        load(8'hC1, 8'h5B, 8'h64, 8'hAD, 8'hF6, 8'h3F, 8'hC7, 8'h52);
        push(8'hC1, 1'b0); push(8'h5B, 1'b0); push(8'h64, 1'b0); push(8'hAD, 1'b0);
        push(8'hF6, 1'b0); push(8'h3F, 1'b0); push(8'hC7, 1'b0); push(8'h52, 1'b0);
        run_prog("restart", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
